// File: rtl/pa_clk_ratio_gen_pkg.sv
// pa_clk_pkg: shared FSM encoding and default widths for the clock-ratio generator and its consumers
package pa_clk_pkg;
  localparam int RATIO_W_DEF = 3;
  localparam int RST_SEL_DEF = 0;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2,
    DROP = 2'd3
  } state_t;
endpackage

// File: rtl/pa_clk_ratio_gen_if.sv
// pa_clk_ratio_gen_if: ratio-change handshake and enable strobes of the clock-ratio generator
interface pa_clk_ratio_gen_if #(
  parameter int RATIO_W = pa_clk_pkg::RATIO_W_DEF
);
  logic [RATIO_W-1:0] ratio_sel;
  logic               ratio_req;
  logic               ratio_ack;
  logic [RATIO_W-1:0] ratio_cur;
  logic               clk_en;
  logic               clk_en_pre;
  modport master (output ratio_sel, ratio_req, input ratio_ack, ratio_cur, clk_en, clk_en_pre);
  modport slave  (input ratio_sel, ratio_req, output ratio_ack, ratio_cur, clk_en, clk_en_pre);
endinterface

// File: rtl/pa_clk_ratio_gen.sv
// pa_clk_ratio_gen: programmable cpuclk enable strobe; ratio changes land only on period boundaries
module pa_clk_ratio_gen
  import pa_clk_pkg::*;
#(
  parameter int RATIO_W = RATIO_W_DEF,
  parameter int RST_SEL = RST_SEL_DEF
) (
  input logic              forever_cpuclk,
  input logic              cpurst,
  pa_clk_ratio_gen_if.slave rif
);
  state_t             state;
  logic [RATIO_W-1:0] cnt;
  logic [RATIO_W-1:0] sel_pend;
  logic [RATIO_W-1:0] ratio_cur;
  logic               clk_en;
  logic               clk_en_pre;
  logic               ratio_ack;
  logic               cnt_zero;
  assign cnt_zero       = cnt == '0;
  assign rif.ratio_cur  = ratio_cur;
  assign rif.clk_en     = clk_en;
  assign rif.clk_en_pre = clk_en_pre;
  assign rif.ratio_ack  = ratio_ack;
  // apply shares the cnt==0 edge with the old period's final strobe, so the reload takes the new N-1
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_pend   <= '0;
      ratio_cur  <= RATIO_W'(RST_SEL);
      clk_en     <= 1'b0;
      clk_en_pre <= 1'b0;
      ratio_ack  <= 1'b0;
    end else begin
      clk_en     <= cnt_zero;
      clk_en_pre <= (ratio_cur != '0) && (cnt == RATIO_W'(1));
      cnt        <= cnt_zero ? ratio_cur : cnt - 1'b1;
      ratio_ack  <= 1'b0;
      case (state)
        IDLE: if (rif.ratio_req) begin
          sel_pend <= rif.ratio_sel;
          state    <= PEND;
        end
        PEND: if (cnt_zero) begin
          ratio_cur <= sel_pend;
          cnt       <= sel_pend;
          ratio_ack <= 1'b1;
          state     <= ACK;
        end
        ACK:  state <= rif.ratio_req ? DROP : IDLE;
        DROP: state <= rif.ratio_req ? DROP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
